// File: rtl/branch_rs_sched.sv
// Branch/jump reservation station: holds dispatched branch ops until both source
// tags are ready, then issues the oldest ready entry to the branch ALU.
module branch_rs_sched #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5,
    parameter int PKT_W  = 128,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both 1; ready never depends on valid in the same cycle.
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [ROB_W-1:0]  disp_rob_idx,
    input  logic [PREG_W-1:0] disp_ps1,
    input  logic [PREG_W-1:0] disp_ps2,
    input  logic              disp_ps1_rdy,
    input  logic              disp_ps2_rdy,
    input  logic [PKT_W-1:0]  disp_pkt,
    input  logic              cdb_valid,
    input  logic [PREG_W-1:0] cdb_pd,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [ROB_W-1:0]  iss_rob_idx,
    output logic [PREG_W-1:0] iss_ps1,
    output logic [PREG_W-1:0] iss_ps2,
    output logic [PKT_W-1:0]  iss_pkt,
    input  logic              flush,
    output logic [OCC_W-1:0]  occupancy
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  rdy1_q, rdy1_d;
    logic [DEPTH-1:0]  rdy2_q, rdy2_d;
    logic [ROB_W-1:0]  rob_q [DEPTH];
    logic [ROB_W-1:0]  rob_d [DEPTH];
    logic [PREG_W-1:0] ps1_q [DEPTH];
    logic [PREG_W-1:0] ps1_d [DEPTH];
    logic [PREG_W-1:0] ps2_q [DEPTH];
    logic [PREG_W-1:0] ps2_d [DEPTH];
    logic [PKT_W-1:0]  pkt_q [DEPTH];
    logic [PKT_W-1:0]  pkt_d [DEPTH];
    // older_q[j][i] is set when entry j was dispatched before entry i.
    logic [DEPTH-1:0]  older_q [DEPTH];
    logic [DEPTH-1:0]  older_d [DEPTH];

    logic [DEPTH-1:0]  elig;
    logic [DEPTH-1:0]  blocked;
    logic [DEPTH-1:0]  sel_oh;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  alloc_idx;
    logic [OCC_W-1:0]  occ;
    logic              do_disp;
    logic              do_iss;

    always_comb begin
        elig    = valid_q & rdy1_q & rdy2_q;
        blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && elig[j] && older_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        sel_oh  = elig & ~blocked;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    assign occupancy  = occ;
    assign disp_ready = (occ < OCC_W'(DEPTH)) && !flush;
    assign iss_valid  = (|elig) && !flush;
    assign do_disp    = disp_valid && disp_ready;
    assign do_iss     = iss_valid && iss_ready;

    // Outputs are zeroed when idle so nothing downstream sees stale slot data.
    assign iss_rob_idx = iss_valid ? rob_q[sel_idx] : '0;
    assign iss_ps1     = iss_valid ? ps1_q[sel_idx] : '0;
    assign iss_ps2     = iss_valid ? ps2_q[sel_idx] : '0;
    assign iss_pkt     = iss_valid ? pkt_q[sel_idx] : '0;

    always_comb begin
        valid_d = valid_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        rob_d   = rob_q;
        ps1_d   = ps1_q;
        ps2_d   = ps2_q;
        pkt_d   = pkt_q;
        older_d = older_q;
        if (cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ps1_q[i] == cdb_pd) rdy1_d[i] = 1'b1;
                if (ps2_q[i] == cdb_pd) rdy2_d[i] = 1'b1;
            end
        end
        if (do_iss) begin
            valid_d[sel_idx] = 1'b0;
        end
        if (do_disp) begin
            valid_d[alloc_idx] = 1'b1;
            rob_d[alloc_idx]   = disp_rob_idx;
            ps1_d[alloc_idx]   = disp_ps1;
            ps2_d[alloc_idx]   = disp_ps2;
            pkt_d[alloc_idx]   = disp_pkt;
            rdy1_d[alloc_idx]  = disp_ps1_rdy || (disp_ps1 == '0) || (cdb_valid && cdb_pd == disp_ps1);
            rdy2_d[alloc_idx]  = disp_ps2_rdy || (disp_ps2 == '0) || (cdb_valid && cdb_pd == disp_ps2);
            // The new entry is younger than every other slot.
            older_d[alloc_idx] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                older_d[j][alloc_idx] = (j != int'(alloc_idx));
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i]   <= '0;
                ps1_q[i]   <= '0;
                ps2_q[i]   <= '0;
                pkt_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            rob_q   <= rob_d;
            ps1_q   <= ps1_d;
            ps2_q   <= ps2_d;
            pkt_q   <= pkt_d;
            older_q <= older_d;
        end
    end

endmodule

// File: doc/branch_rs_sched.md
BRANCH_RS_SCHED -- requirements
Module: branch_rs_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of branch/jump reservation entries (power of two, 2..8).
REQ-002 The block SHALL have parameter PREG_W, default 6, meaning the physical register tag width.
REQ-003 The block SHALL have parameter ROB_W, default 5, meaning the ROB index width.
REQ-004 The block SHALL have parameter PKT_W, default 128, meaning the width of the opaque branch-unit packet (op selects, pc, pc_next, imm) carried unchanged to issue.
REQ-005 The block SHALL have port clk, input, 1, the single clock; every state element updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-007 The block SHALL have these dispatch ports: disp_valid in 1; disp_ready out 1; disp_rob_idx in ROB_W; disp_ps1 and disp_ps2 in PREG_W each; disp_ps1_rdy and disp_ps2_rdy in 1 each; disp_pkt in PKT_W.
REQ-008 The block SHALL have these wakeup ports: cdb_valid in 1 and cdb_pd in PREG_W, a physical tag broadcast as written this cycle.
REQ-009 The block SHALL have these issue ports: iss_valid out 1; iss_ready in 1 (branch ALU free); iss_rob_idx out ROB_W; iss_ps1 and iss_ps2 out PREG_W each; iss_pkt out PKT_W.
REQ-010 The block SHALL have flush in 1, a mispredict/exception kill of all held entries.
REQ-011 The block SHALL have occupancy out clog2(DEPTH)+1, the number of valid entries.

Function
REQ-012 Each entry SHALL hold valid, rob_idx, ps1, ps2, rdy1, rdy2 and pkt.
REQ-013 disp_ready SHALL be 1 iff occupancy < DEPTH and flush = 0, computed from the current registered state; same-cycle issue does not raise it.
REQ-014 On disp_valid && disp_ready, a free entry SHALL be written at the clock edge with all dispatch fields.
REQ-015 An entry's rdyN SHALL be set when any of these holds: disp_psN_rdy=1; psN=0 (x0 always ready); or cdb_valid && cdb_pd==psN in the dispatch cycle.
REQ-016 Every valid entry SHALL set rdyN at the edge where cdb_valid && cdb_pd==psN, independently for ps1 and ps2; one broadcast may wake multiple entries.
REQ-017 An entry SHALL be eligible when valid && rdy1 && rdy2, using registered bits only; a wakeup in cycle t makes the entry issuable in cycle t+1 at the earliest.
REQ-018 The select SHALL be combinational: the oldest eligible entry in dispatch order, regardless of slot position or wrap-around of any internal allocation pointer/stamp.
REQ-019 iss_valid SHALL be 1 iff at least one entry is eligible and flush = 0; iss_* SHALL present the selected entry's fields.
REQ-020 The issued entry SHALL be invalidated at the edge where iss_valid && iss_ready hold; at most one issue occurs per cycle.
REQ-021 When iss_valid = 1 && iss_ready = 0, iss_* SHALL stay stable unless an older entry becomes eligible.
REQ-022 Dispatch and issue in the same cycle SHALL both take effect; occupancy changes by +1, -1, or 0 accordingly.
REQ-023 On flush = 1, every entry SHALL be invalidated at that edge; same-cycle dispatch and issue are discarded, and occupancy is 0 in the next cycle.
REQ-024 Age order SHALL be maintained across arbitrary interleavings of dispatch, issue and flush; dispatch order is the only ordering criterion.
REQ-025 The block SHALL never issue an entry twice and SHALL never drop a non-flushed entry.

Reset
REQ-026 While rst = 1 at a clock edge, all entries SHALL become invalid and occupancy SHALL be 0; in the following cycle iss_valid = 0 and disp_ready = 1.
REQ-027 rst SHALL take priority over flush, dispatch, wakeup and issue in the same cycle, including reset asserted mid-stream with full occupancy.
REQ-028 No output SHALL depend on uninitialised state after the first reset edge.

Verification
REQ-029 Ordering: dispatch A (rob 3, ps1=5 not ready), B (rob 4, both ready), C (rob 5, both ready), iss_ready=1 -> B issues, then C; cdb_pd=5 in cycle t -> A issues in t+1.
REQ-030 Full/backpressure: DEPTH=4, four dispatches, iss_ready=0 -> disp_ready=0, occupancy=4, iss_* stable; iss_ready=1 for one cycle -> occupancy=3, disp_ready=1 in the next cycle.
REQ-031 Same-cycle wakeup: dispatch ps1=9, disp_ps1_rdy=0 with cdb_valid=1, cdb_pd=9 -> entry ready and iss_valid=1 in the next cycle; disp_ps2=0 -> treated as ready.
REQ-032 Flush: three entries held, flush=1 with disp_valid=1 and iss_ready=1 -> nothing issued, occupancy=0, iss_valid=0 in the next cycle.
REQ-033 Wrap-around: 20 cycles of continuous dispatch+issue with random readiness -> issue order equals dispatch order among simultaneously eligible entries, with no loss or duplication.
REQ-034 Reset mid-operation: occupancy=4, rst=1 with disp_valid=1 -> occupancy=0, disp_ready=1, iss_valid=0 in the next cycle.
